// File: rtl/intr_seq.sv
// intr_seq: interrupt entry/exit sequencer.
// Edge-samples four level request lines into a pending register.
// On an instruction retire in IDLE it accepts one unmasked pending source,
// saves the return address and redirects the PC to the source's vector.
// Return-from-interrupt restores the saved PC.
// Optional feature: define INTR_SEQ_ROUND_ROBIN_EN to use round-robin
// selection. The default build uses fixed priority, lowest index first.
`timescale 1ns/1ps

module intr_seq #(
  parameter logic [7:0] VECTOR_BASE = 8'hF0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       retire,
  input  logic       reti,
  input  logic [7:0] pc_next,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  output logic       intr_en,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic [3:0] ack,
  output logic [3:0] pending,
  output logic [3:0] mask
);

  localparam int NIRQ = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTER   = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [1:0] EXIT    = 2'd3;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [NIRQ-1:0] irq_q_r;
  logic [NIRQ-1:0] pending_r;
  logic [NIRQ-1:0] mask_r;
  logic [7:0]      epc_r;
  logic            intr_en_r;
  logic            pc_load_r;
  logic [7:0]      pc_target_r;
  logic [7:0]      tgt_nxt_s;
  logic [NIRQ-1:0] rise_s;
  logic [NIRQ-1:0] eligible_s;
  logic [1:0]      sel_id_s;
  logic            accept_s;
  logic [NIRQ-1:0] ack_s;

`ifdef INTR_SEQ_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_r;

  // First requesting index at or after start, wrapping modulo 4.
  function automatic logic [1:0] pick_rr(input logic [NIRQ-1:0] req,
                                         input logic [1:0] start);
    logic [1:0] id;
    logic [1:0] idx;
    logic       found;
    id    = start;
    found = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        id    = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return id;
  endfunction

  assign sel_id_s = pick_rr(eligible_s, rr_ptr_r + 2'd1);
`else
  // Lowest requesting index wins.
  function automatic logic [1:0] pick_fixed(input logic [NIRQ-1:0] req);
    logic [1:0] id;
    casez (req)
      4'b???1: id = 2'd0;
      4'b??10: id = 2'd1;
      4'b?100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return id;
  endfunction

  assign sel_id_s = pick_fixed(eligible_s);
`endif

  // Acceptance looks at the mask as it stands this cycle, before any write.
  assign rise_s     = irq & ~irq_q_r;
  assign eligible_s = pending_r & ~mask_r;
  assign accept_s   = (state_r == IDLE) && retire && (eligible_s != 4'b0000);

  // One-hot acknowledge in the acceptance cycle itself.
  always_comb begin
    ack_s = 4'b0000;
    if (accept_s) begin
      ack_s = 4'b0001 << sel_id_s;
    end else begin
      ack_s = 4'b0000;
    end
  end

  // Sequencer next state; reti is only honoured while servicing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = ENTER;
        else          state_nxt_s = IDLE;
      end
      ENTER:   state_nxt_s = SERVICE;
      SERVICE: begin
        if (retire && reti) state_nxt_s = EXIT;
        else                state_nxt_s = SERVICE;
      end
      EXIT:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // PC redirect target for the state being entered; zero when not loading.
  always_comb begin
    tgt_nxt_s = 8'h00;
    case (state_nxt_s)
      ENTER:   tgt_nxt_s = VECTOR_BASE + {4'b0000, sel_id_s, 2'b00};
      EXIT:    tgt_nxt_s = epc_r;
      default: tgt_nxt_s = 8'h00;
    endcase
  end

  // State, return address and registered outputs decoded from next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      epc_r       <= 8'h00;
      intr_en_r   <= 1'b0;
      pc_load_r   <= 1'b0;
      pc_target_r <= 8'h00;
    end else begin
      state_r     <= state_nxt_s;
      epc_r       <= accept_s ? pc_next : epc_r;
      intr_en_r   <= (state_nxt_s == ENTER) || (state_nxt_s == SERVICE);
      pc_load_r   <= (state_nxt_s == ENTER) || (state_nxt_s == EXIT);
      pc_target_r <= tgt_nxt_s;
    end
  end

  // Edge sampler and pending latch; a new edge beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q_r   <= 4'b0000;
      pending_r <= 4'b0000;
    end else begin
      irq_q_r   <= irq;
      pending_r <= (pending_r & ~ack_s) | rise_s;
    end
  end

  // Mask register, writable in any state; all sources masked out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_r <= 4'hF;
    end else if (mask_we) begin
      mask_r <= mask_wdata;
    end else begin
      mask_r <= mask_r;
    end
  end

`ifdef INTR_SEQ_ROUND_ROBIN_EN
  // Remember the last accepted source so the next search starts after it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= 2'd3;
    end else if (accept_s) begin
      rr_ptr_r <= sel_id_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  assign intr_en   = intr_en_r;
  assign pc_load   = pc_load_r;
  assign pc_target = pc_target_r;
  assign ack       = ack_s;
  assign pending   = pending_r;
  assign mask      = mask_r;

endmodule

// File: tb/tb_intr_seq.sv
// tb_intr_seq: table-driven bench for intr_seq with an expected-output queue.
`timescale 1ns/1ps

module tb_intr_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       retire;
  logic       reti;
  logic [7:0] pc_next;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       intr_en;
  logic       pc_load;
  logic [7:0] pc_target;
  logic [3:0] ack;
  logic [3:0] pending;
  logic [3:0] mask;

  int n_total  = 0;
  int n_passed = 0;

  intr_seq dut (
    .clock      (clock),
    .reset      (reset),
    .irq        (irq),
    .retire     (retire),
    .reti       (reti),
    .pc_next    (pc_next),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .intr_en    (intr_en),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .ack        (ack),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] irq;
    logic       retire;
    logic       reti;
    logic [7:0] pc_next;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] ack;        // same-cycle acknowledge
    logic       intr_en;    // values after the following clock edge
    logic       pc_load;
    logic [7:0] pc_target;
    logic [3:0] pending;
    logic [3:0] mask;
  } vec_t;

  typedef struct packed {
    logic       intr_en;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [3:0] pending;
    logic [3:0] mask;
  } post_t;

  localparam int NV = 25;
  vec_t  vecs [NV];
  post_t exp_q[$];

  function automatic vec_t mk(logic [3:0] i_irq, logic i_ret, logic i_reti,
                              logic [7:0] i_pc, logic i_mwe, logic [3:0] i_mwd,
                              logic [3:0] e_ack, logic e_ie, logic e_pl,
                              logic [7:0] e_tgt, logic [3:0] e_pend,
                              logic [3:0] e_mask);
    vec_t v;
    v = '{i_irq, i_ret, i_reti, i_pc, i_mwe, i_mwd,
          e_ack, e_ie, e_pl, e_tgt, e_pend, e_mask};
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] i_irq, logic i_ret, logic i_reti,
                       logic [7:0] i_pc, logic i_mwe, logic [3:0] i_mwd);
    irq = i_irq; retire = i_ret; reti = i_reti;
    pc_next = i_pc; mask_we = i_mwe; mask_wdata = i_mwd;
  endtask

  initial begin
    post_t e;
    string tag;

    //          irq  rt reti pc     mwe mwd   ack   ie pl tgt    pend   mask
    vecs[0]  = mk(4'h0,1'b0,1'b0,8'h00,1'b1,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h0,4'h0);
    vecs[1]  = mk(4'h4,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h4,4'h0);
    vecs[2]  = mk(4'h4,1'b1,1'b0,8'h23,1'b0,4'h0, 4'h4,1'b1,1'b1,8'hF8,4'h0,4'h0);
    vecs[3]  = mk(4'h4,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h0,4'h0);
    vecs[4]  = mk(4'h0,1'b1,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h0,4'h0);
    vecs[5]  = mk(4'h0,1'b1,1'b1,8'h77,1'b0,4'h0, 4'h0,1'b0,1'b1,8'h23,4'h0,4'h0);
    vecs[6]  = mk(4'h0,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h0,4'h0);
    vecs[7]  = mk(4'h0,1'b1,1'b1,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h0,4'h0);
    vecs[8]  = mk(4'hA,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'hA,4'h0);
    vecs[9]  = mk(4'hA,1'b1,1'b0,8'h40,1'b0,4'h0, 4'h2,1'b1,1'b1,8'hF4,4'h8,4'h0);
    vecs[10] = mk(4'h0,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h8,4'h0);
    vecs[11] = mk(4'h0,1'b1,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h8,4'h0);
    vecs[12] = mk(4'h0,1'b1,1'b1,8'h99,1'b0,4'h0, 4'h0,1'b0,1'b1,8'h40,4'h8,4'h0);
    vecs[13] = mk(4'h0,1'b1,1'b0,8'hAA,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h8,4'h0);
    vecs[14] = mk(4'h0,1'b1,1'b0,8'h51,1'b0,4'h0, 4'h8,1'b1,1'b1,8'hFC,4'h0,4'h0);
    vecs[15] = mk(4'h0,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h0,4'h0);
    vecs[16] = mk(4'h0,1'b0,1'b0,8'h00,1'b1,4'h1, 4'h0,1'b1,1'b0,8'h00,4'h0,4'h1);
    vecs[17] = mk(4'h0,1'b1,1'b1,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b1,8'h51,4'h0,4'h1);
    vecs[18] = mk(4'h0,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h0,4'h1);
    vecs[19] = mk(4'h1,1'b0,1'b0,8'h00,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h1,4'h1);
    vecs[20] = mk(4'h1,1'b1,1'b0,8'h12,1'b0,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h1,4'h1);
    vecs[21] = mk(4'h0,1'b1,1'b0,8'h13,1'b1,4'h0, 4'h0,1'b0,1'b0,8'h00,4'h1,4'h0);
    vecs[22] = mk(4'h1,1'b1,1'b0,8'h66,1'b0,4'h0, 4'h1,1'b1,1'b1,8'hF0,4'h1,4'h0);
    vecs[23] = mk(4'h1,1'b1,1'b1,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h1,4'h0);
    vecs[24] = mk(4'h1,1'b0,1'b1,8'h00,1'b0,4'h0, 4'h0,1'b1,1'b0,8'h00,4'h1,4'h0);

    // Reset state.
    reset = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_intr_en",   32'(intr_en),   32'h0);
    check("rst_pc_load",   32'(pc_load),   32'h0);
    check("rst_pc_target", 32'(pc_target), 32'h00);
    check("rst_ack",       32'(ack),       32'h0);
    check("rst_pending",   32'(pending),   32'h0);
    check("rst_mask",      32'(mask),      32'hF);
    @(negedge clock);
    reset = 1'b0;

    // Table: drive, check same-cycle ack, queue post-edge expectations.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].irq, vecs[i].retire, vecs[i].reti, vecs[i].pc_next,
            vecs[i].mask_we, vecs[i].mask_wdata);
      #1;
      tag = $sformatf("v%0d_", i);
      check({tag, "ack"}, 32'(ack), 32'(vecs[i].ack));
      exp_q.push_back('{vecs[i].intr_en, vecs[i].pc_load, vecs[i].pc_target,
                        vecs[i].pending, vecs[i].mask});
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check({tag, "intr_en"},   32'(intr_en),   32'(e.intr_en));
      check({tag, "pc_load"},   32'(pc_load),   32'(e.pc_load));
      check({tag, "pc_target"}, 32'(pc_target), 32'(e.pc_target));
      check({tag, "pending"},   32'(pending),   32'(e.pending));
      check({tag, "mask"},      32'(mask),      32'(e.mask));
    end

    // Asynchronous reset mid-SERVICE, no clock edge in between.
    #2;
    reset = 1'b1;
    #1;
    check("async_intr_en",   32'(intr_en),   32'h0);
    check("async_pending",   32'(pending),   32'h0);
    check("async_mask",      32'(mask),      32'hF);
    check("async_pc_load",   32'(pc_load),   32'h0);
    check("async_pc_target", 32'(pc_target), 32'h00);

    // The abandoned service must not produce a return redirect.
    drive(4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0);
    @(posedge clock);
    #1;
    check("rst_hold_pc_load", 32'(pc_load), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_pc_load", 32'(pc_load), 32'h0);
    check("post_rst_intr_en", 32'(intr_en), 32'h0);

    // Masked out of reset: an edge becomes pending but is never accepted.
    drive(4'h2, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    @(posedge clock);
    #1;
    drive(4'h2, 1'b1, 1'b0, 8'h10, 1'b0, 4'h0);
    #1;
    check("masked_ack", 32'(ack), 32'h0);
    @(posedge clock);
    #1;
    check("masked_pending", 32'(pending), 32'h2);
    check("masked_pc_load", 32'(pc_load), 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
